mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_grant.sv | 37 +++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter:
// grant encoding, default burst cap and counter width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DMA  = 2'b10
  } gnt_t;

  localparam int unsigned DMA_MAX_BURST_DEF = 4;

  // Width of a counter that must hold 0..max, never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Pure combinational grant decision between CPU and DMA.
// Ports: en, cpu_req, dma_req, burst_cnt, burst_max -> cpu_gnt, dma_gnt.
module arb_grant #(
  parameter int unsigned CW = 3
) (
  input  logic          en,
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic [CW-1:0] burst_cnt,
  input  logic [CW-1:0] burst_max,
  output logic          cpu_gnt,
  output logic          dma_gnt
);

  logic both;
  logic capped;

  assign both   = cpu_req & dma_req;
  assign capped = (burst_cnt == burst_max);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    unique case (1'b1)
      (!en): ;
      (en && both): begin
        // DMA wins conflicts until the CPU has waited long enough.
        cpu_gnt = capped;
        dma_gnt = !capped;
      end
      (en && cpu_req && !dma_req): cpu_gnt = 1'b1;
      (en && !cpu_req && dma_req): dma_gnt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared data-memory arbiter: CPU M-stage vs DMA, DMA-first with a burst cap.
// Ports: clk, reset (async low), cpu_*, dma_*, mem_* bus toward DM/bridge.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DMA_MAX_BURST = DMA_MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_kill,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_be,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = cnt_w(DMA_MAX_BURST);
  localparam logic [CW-1:0] BMAX = CW'(DMA_MAX_BURST);

  logic [CW-1:0] burst_cnt;
  gnt_t          last_gnt;
  gnt_t          cur_gnt;
  logic          cpu_gnt;

  arb_grant #(
    .CW(CW)
  ) u_grant (
    .en       (reset),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .burst_cnt(burst_cnt),
    .burst_max(BMAX),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt)
  );

  always_comb begin
    cur_gnt   = GNT_NONE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    unique case (1'b1)
      cpu_gnt: begin
        cur_gnt   = GNT_CPU;
        // A killed access keeps its slot but must not write.
        mem_we    = cpu_we & ~cpu_kill;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
      end
      dma_gnt: begin
        cur_gnt   = GNT_DMA;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_be    = dma_be;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
      last_gnt  <= GNT_NONE;
      dma_done  <= 1'b0;
      dma_rdata <= '0;
    end else begin
      last_gnt <= cur_gnt;
      dma_done <= dma_gnt;
      if (dma_gnt) dma_rdata <= mem_rdata;
      // Count only DMA grants the CPU is waiting behind.
      if (dma_gnt && cpu_req) begin
        if (burst_cnt != BMAX) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-enabled word memory model.
// A second instance with DMA_MAX_BURST = 0 checks absolute CPU priority.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_kill;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_gnt, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] c0_rdata, d0_rdata, m0_addr, m0_wdata;
  logic        c0_stall, d0_gnt, d0_done, m0_we;
  logic [3:0]  m0_be;

  logic [31:0] dm [0:16383];
  logic        rd_force;
  logic [31:0] rd_val;

  int vecs = 0;
  int errs = 0;

  mem_arbiter #(.DMA_MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_kill(cpu_kill),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_be(dma_be),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.DMA_MAX_BURST(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_kill(cpu_kill),
    .cpu_rdata(c0_rdata), .cpu_stall(c0_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_be(dma_be),
    .dma_gnt(d0_gnt), .dma_done(d0_done), .dma_rdata(d0_rdata),
    .mem_we(m0_we), .mem_addr(m0_addr), .mem_wdata(m0_wdata),
    .mem_be(m0_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = rd_force ? rd_val : dm[mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dm[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic test_reset;
    reset = 1'b0;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    #2;
    vecs++;
    if (dma_gnt !== 1'b0) begin
      errs++; $display("FAIL rst_dma_gnt got %0b want 0", dma_gnt);
    end
    vecs++;
    if (cpu_stall !== 1'b1) begin
      errs++; $display("FAIL rst_cpu_stall got %0b want 1", cpu_stall);
    end
    vecs++;
    if (mem_we !== 1'b0) begin
      errs++; $display("FAIL rst_mem_we got %0b want 0", mem_we);
    end
    vecs++;
    if ({dma_done, dma_rdata} !== 33'h0) begin
      errs++; $display("FAIL rst_dma_out got %0b/%h want 0/0", dma_done, dma_rdata);
    end
    vecs++;
    if (dut.last_gnt !== GNT_NONE || dut.burst_cnt !== 3'd0) begin
      errs++; $display("FAIL rst_state got %0d/%0d want 0/0", dut.last_gnt, dut.burst_cnt);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_cpu_write;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
    cpu_wdata = 32'h1234_5678; cpu_be = 4'hf;
    #1;
    vecs++;
    if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
      errs++; $display("FAIL cpuw_we_stall got %0b/%0b want 1/0", mem_we, cpu_stall);
    end
    vecs++;
    if (mem_addr !== 32'h10 || mem_wdata !== 32'h1234_5678) begin
      errs++; $display("FAIL cpuw_bus got %h/%h want 10/12345678", mem_addr, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    vecs++;
    if (dm[4] !== 32'h1234_5678) begin
      errs++; $display("FAIL cpuw_dm4 got %h want 12345678", dm[4]);
    end
    vecs++;
    if (cpu_rdata !== 32'h1234_5678) begin
      errs++; $display("FAIL cpur_rdata got %h want 12345678", cpu_rdata);
    end
    vecs++;
    if (dut.last_gnt !== GNT_CPU) begin
      errs++; $display("FAIL cpuw_last got %0d want 1", dut.last_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic test_conflict;
    logic [5:0] exp_d = 6'b101111;
    int         exp_c [6] = '{0, 1, 2, 3, 4, 0};
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      #1;
      vecs++;
      if (dma_gnt !== exp_d[i] || cpu_stall !== exp_d[i]) begin
        errs++;
        $display("FAIL conf_gnt%0d got gnt %0b stall %0b want %0b", i, dma_gnt, cpu_stall, exp_d[i]);
      end
      vecs++;
      if (int'(dut.burst_cnt) !== exp_c[i]) begin
        errs++; $display("FAIL conf_cnt%0d got %0d want %0d", i, dut.burst_cnt, exp_c[i]);
      end
      vecs++;
      if (d0_gnt !== 1'b0 || c0_stall !== 1'b0) begin
        errs++; $display("FAIL max0_cpu%0d got gnt %0b stall %0b want 0/0", i, d0_gnt, c0_stall);
      end
      if (i > 0) begin
        vecs++;
        if (dma_done !== exp_d[i-1]) begin
          errs++; $display("FAIL conf_done%0d got %0b want %0b", i, dma_done, exp_d[i-1]);
        end
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_dma_read;
    @(negedge clk);
    rd_force = 1'b1; rd_val = 32'hCAFE_0001;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h7f04; dma_be = 4'hf;
    #1;
    vecs++;
    if (dma_gnt !== 1'b1 || mem_addr !== 32'h7f04 || mem_we !== 1'b0) begin
      errs++; $display("FAIL dmar_gnt got %0b %h %0b want 1 7f04 0", dma_gnt, mem_addr, mem_we);
    end
    @(negedge clk);
    dma_req = 1'b0; rd_force = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    vecs++;
    if (dma_done !== 1'b1 || dma_rdata !== 32'hCAFE_0001) begin
      errs++; $display("FAIL dmar_done got %0b %h want 1 cafe0001", dma_done, dma_rdata);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    vecs++;
    if (dma_done !== 1'b0 || dma_rdata !== 32'hCAFE_0001) begin
      errs++; $display("FAIL dmar_hold got %0b %h want 0 cafe0001", dma_done, dma_rdata);
    end
  endtask

  task automatic test_kill;
    logic [4:0] exp_d = 5'b01111;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_kill = 1'b0;
    cpu_addr = 32'h20; cpu_wdata = 32'hAAAA_5555; cpu_be = 4'hf;
    @(negedge clk);
    #1;
    vecs++;
    if (dm[8] !== 32'hAAAA_5555) begin
      errs++; $display("FAIL kill_pre got %h want aaaa5555", dm[8]);
    end
    cpu_kill = 1'b1; cpu_wdata = 32'hDEAD_BEEF;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if (dma_gnt !== exp_d[i]) begin
        errs++; $display("FAIL kill_gnt%0d got %0b want %0b", i, dma_gnt, exp_d[i]);
      end
      if (i == 4) begin
        vecs++;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h20) begin
          errs++;
          $display("FAIL kill_cpu got we %0b stall %0b addr %h want 0 0 20", mem_we, cpu_stall, mem_addr);
        end
      end
      @(negedge clk);
    end
    cpu_req = 1'b0; cpu_kill = 1'b0; cpu_we = 1'b0;
    #1;
    vecs++;
    if (dm[8] !== 32'hAAAA_5555) begin
      errs++; $display("FAIL kill_dm8 got %h want aaaa5555", dm[8]);
    end
    vecs++;
    if (dma_gnt !== 1'b1 || dut.last_gnt !== GNT_CPU || dut.burst_cnt !== 3'd0) begin
      errs++;
      $display("FAIL kill_after got gnt %0b last %0d cnt %0d want 1 1 0", dma_gnt, dut.last_gnt, dut.burst_cnt);
    end
    @(negedge clk);
    dma_req = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [4:0] exp_d = 5'b01111;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h48;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    vecs++;
    if (dut.burst_cnt !== 3'd3 || dma_done !== 1'b1) begin
      errs++; $display("FAIL arst_pre got cnt %0d done %0b want 3 1", dut.burst_cnt, dma_done);
    end
    #2;
    reset = 1'b0;
    #1;
    vecs++;
    if (dut.burst_cnt !== 3'd0 || dma_done !== 1'b0) begin
      errs++; $display("FAIL arst_now got cnt %0d done %0b want 0 0", dut.burst_cnt, dma_done);
    end
    vecs++;
    if (dma_gnt !== 1'b0 || cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      errs++; $display("FAIL arst_gnt got %0b %0b %0b want 0 1 0", dma_gnt, cpu_stall, mem_we);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if (dma_gnt !== exp_d[i] || int'(dut.burst_cnt) !== i) begin
        errs++;
        $display("FAIL arst_run%0d got gnt %0b cnt %0d want %0b %0d", i, dma_gnt, dut.burst_cnt, exp_d[i], i);
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_idle;
    @(negedge clk);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    cpu_addr = 32'h1234; cpu_wdata = 32'h5555; cpu_be = 4'h3;
    dma_addr = 32'h4321; dma_wdata = 32'h6666; dma_be = 4'hc;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if ({mem_we, mem_addr, mem_wdata, mem_be} !== 69'h0) begin
        errs++;
        $display("FAIL idle_bus%0d got %0b %h %h %h want all 0", i, mem_we, mem_addr, mem_wdata, mem_be);
      end
      @(negedge clk);
    end
    #1;
    vecs++;
    if (dut.last_gnt !== GNT_NONE || dut.burst_cnt !== 3'd0) begin
      errs++; $display("FAIL idle_state got %0d %0d want 0 0", dut.last_gnt, dut.burst_cnt);
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_kill = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    dma_req = 1'b0; dma_we = 1'b0;
    dma_addr = '0; dma_wdata = '0; dma_be = '0;
    rd_force = 1'b0; rd_val = '0;
    test_reset();
    test_cpu_write();
    test_conflict();
    test_dma_read();
    test_kill();
    test_async_reset();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
